uart_pixel_writer: RTL and testbench

- Sits between the UART receiver and the framebuffer write port in the vga_uart design.
- Decodes the incoming byte stream:
  - Sync byte (MSB=1) restarts the frame.
  - Data bytes (MSB=0) are paired into 12-bit RGB444 pixels.
- Each completed pixel is written at a sequential address over the 320x240 framebuffer.
- Detects framing and phase errors and inter-byte timeouts, and signals frame completion.

---
 rtl/vga_uart_pkg.sv | 33 +++
 rtl/uart_pixel_writer_if.sv | 24 ++
 rtl/byte_timeout_timer.sv | 37 +++
 rtl/uart_pixel_writer.sv | 142 ++++++++++++++
 tb/tb_uart_pixel_writer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/vga_uart_pkg.sv
// Shared types and constants for the vga_uart byte-stream to framebuffer path.
package vga_uart_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    EXP_HI    = 2'd1,
    EXP_LO    = 2'd2
  } state_t;

  localparam int H_RES        = 320;
  localparam int V_RES        = 240;
  localparam int FRAME_PIXELS = H_RES * V_RES;

  localparam int         SYNC_BIT = 7;
  localparam logic [1:0] TAG_HI   = 2'b00;
  localparam logic [1:0] TAG_LO   = 2'b01;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // HI half carries {r, g[3:2]}, LO half carries {g[1:0], b}.
  function automatic pixel_t make_pixel(input logic [5:0] hi, input logic [5:0] lo);
    make_pixel = {hi, lo};
  endfunction

endpackage

// File: rtl/uart_pixel_writer_if.sv
// Byte-in / framebuffer-write-out bundle of the UART pixel writer.
interface uart_pixel_writer_if #(
  parameter int ADDR_W = 17
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;
  logic [ADDR_W-1:0] addr_count;
  logic              frame_done;
  logic [7:0]        err_count;
  logic              busy;

  modport master (
    output rx_data, rx_valid,
    input  wr_en, wr_addr, wr_data, addr_count, frame_done, err_count, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output wr_en, wr_addr, wr_data, addr_count, frame_done, err_count, busy
  );
endinterface

// File: rtl/byte_timeout_timer.sv
// Idle-clock counter; expired is high for the one cycle in which the count
// sits at TIMEOUT_CLKS-1 while enabled.
module byte_timeout_timer #(
  parameter int TIMEOUT_CLKS = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int             CW   = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CLKS - 1);
  localparam logic [CW-1:0]  PRE  = CW'(TIMEOUT_CLKS - 2);

  logic [CW-1:0] cnt_r;
  logic          expired_r;

  // Count while enabled; expired is registered one step ahead of the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= '0;
      expired_r <= 1'b0;
    end else begin
      expired_r <= enable && !clear && (cnt_r == PRE);
      if (clear || !enable) begin
        cnt_r <= '0;
      end else if (cnt_r != LAST) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign expired = expired_r;
endmodule

// File: rtl/uart_pixel_writer.sv
// Decodes sync/HI/LO UART bytes into RGB444 pixels and writes them at
// sequential framebuffer addresses, counting protocol errors.
module uart_pixel_writer
  import vga_uart_pkg::*;
#(
  parameter int H_RES        = vga_uart_pkg::H_RES,
  parameter int V_RES        = vga_uart_pkg::V_RES,
  parameter int ADDR_W       = 17,
  parameter int TIMEOUT_CLKS = 2000
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_pixel_writer_if.slave   bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  state_t            state_r, state_nx;
  logic [5:0]        hi_r, hi_nx;
  logic [ADDR_W-1:0] addr_count_r, addr_count_nx;
  logic [7:0]        err_count_r, err_count_nx;
  logic              wr_en_r, frame_done_r;
  logic [ADDR_W-1:0] wr_addr_r;
  pixel_t            wr_data_r;

  logic is_sync_s, is_hi_s, frame_last_s;
  logic pix_done_s, tmr_clear_s, tmr_enable_s, tmr_expired_s;

  assign is_sync_s    = bus.rx_data[SYNC_BIT];
  assign is_hi_s      = (bus.rx_data[7:6] == TAG_HI);
  assign frame_last_s = (addr_count_r == LAST_ADDR);
  assign tmr_enable_s = (state_r == EXP_LO);

  byte_timeout_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear_s),
    .enable  (tmr_enable_s),
    .expired (tmr_expired_s)
  );

  // Next-state, partial-pixel, address and error-count decisions.
  always_comb begin
    state_nx      = state_r;
    hi_nx         = hi_r;
    addr_count_nx = addr_count_r;
    err_count_nx  = err_count_r;
    pix_done_s    = 1'b0;
    tmr_clear_s   = 1'b0;
    case (state_r)
      WAIT_SYNC: begin
        if (bus.rx_valid && is_sync_s) begin
          addr_count_nx = '0;
          state_nx      = EXP_HI;
        end else begin
          state_nx = WAIT_SYNC;
        end
      end
      EXP_HI: begin
        if (!bus.rx_valid) begin
          state_nx = EXP_HI;
        end else if (is_sync_s) begin
          addr_count_nx = '0;
        end else if (is_hi_s) begin
          hi_nx       = bus.rx_data[5:0];
          tmr_clear_s = 1'b1;
          state_nx    = EXP_LO;
        end else begin
          err_count_nx = sat_inc8(err_count_r);
        end
      end
      EXP_LO: begin
        // A byte arriving in the expiry cycle wins over the timeout.
        if (bus.rx_valid && is_sync_s) begin
          hi_nx         = 6'd0;
          err_count_nx  = sat_inc8(err_count_r);
          addr_count_nx = '0;
          state_nx      = EXP_HI;
        end else if (bus.rx_valid && is_hi_s) begin
          hi_nx        = bus.rx_data[5:0];
          err_count_nx = sat_inc8(err_count_r);
          tmr_clear_s  = 1'b1;
        end else if (bus.rx_valid) begin
          pix_done_s    = 1'b1;
          addr_count_nx = frame_last_s ? '0 : addr_count_r + ADDR_W'(1);
          state_nx      = frame_last_s ? WAIT_SYNC : EXP_HI;
        end else if (tmr_expired_s) begin
          hi_nx        = 6'd0;
          err_count_nx = sat_inc8(err_count_r);
          state_nx     = EXP_HI;
        end else begin
          state_nx = EXP_LO;
        end
      end
      default: begin
        state_nx = WAIT_SYNC;
      end
    endcase
  end

  // State, partial pixel and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= WAIT_SYNC;
      hi_r         <= 6'd0;
      addr_count_r <= '0;
      err_count_r  <= 8'd0;
    end else begin
      state_r      <= state_nx;
      hi_r         <= hi_nx;
      addr_count_r <= addr_count_nx;
      err_count_r  <= err_count_nx;
    end
  end

  // Registered write port; address and data hold between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_r      <= 1'b0;
      frame_done_r <= 1'b0;
      wr_addr_r    <= '0;
      wr_data_r    <= '0;
    end else begin
      wr_en_r      <= pix_done_s;
      frame_done_r <= pix_done_s && frame_last_s;
      if (pix_done_s) begin
        wr_addr_r <= addr_count_r;
        wr_data_r <= make_pixel(hi_r, bus.rx_data[5:0]);
      end else begin
        wr_addr_r <= wr_addr_r;
        wr_data_r <= wr_data_r;
      end
    end
  end

  assign bus.wr_en      = wr_en_r;
  assign bus.wr_addr    = wr_addr_r;
  assign bus.wr_data    = wr_data_r;
  assign bus.addr_count = addr_count_r;
  assign bus.frame_done = frame_done_r;
  assign bus.err_count  = err_count_r;
  assign bus.busy       = (state_r != WAIT_SYNC);
endmodule

// File: tb/tb_uart_pixel_writer.sv
// Directed bench for uart_pixel_writer using a 4x2 frame.
module tb_uart_pixel_writer;
  localparam int T  = 2000;
  localparam int AW = 17;

  typedef struct {
    logic [7:0]    data;
    logic          wr;
    logic [AW-1:0] addr;
    logic [11:0]   pix;
    logic [AW-1:0] cnt;
    logic [7:0]    err;
    logic          busy;
  } vec_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  vec_t vecs[15];

  uart_pixel_writer_if #(.ADDR_W(AW)) bus ();

  uart_pixel_writer #(
    .H_RES(4), .V_RES(2), .ADDR_W(AW), .TIMEOUT_CLKS(T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " wr_en"},      32'(bus.wr_en),      32'd0);
    chk({tag, " wr_addr"},    32'(bus.wr_addr),    32'd0);
    chk({tag, " wr_data"},    32'(bus.wr_data),    32'd0);
    chk({tag, " addr_count"}, 32'(bus.addr_count), 32'd0);
    chk({tag, " frame_done"}, 32'(bus.frame_done), 32'd0);
    chk({tag, " err_count"},  32'(bus.err_count),  32'd0);
    chk({tag, " busy"},       32'(bus.busy),       32'd0);
  endtask

  initial begin
    logic       wr_seen;
    logic [5:0] h6;
    logic [5:0] l6;
    n_pass  = 0;
    n_total = 0;

    vecs[0]  = '{8'h12, 1'b0, 17'd0, 12'h000, 17'd0, 8'd0, 1'b0};
    vecs[1]  = '{8'h74, 1'b0, 17'd0, 12'h000, 17'd0, 8'd0, 1'b0};
    vecs[2]  = '{8'h80, 1'b0, 17'd0, 12'h000, 17'd0, 8'd0, 1'b1};
    vecs[3]  = '{8'h12, 1'b0, 17'd0, 12'h000, 17'd0, 8'd0, 1'b1};
    vecs[4]  = '{8'h74, 1'b1, 17'd0, 12'h4B4, 17'd1, 8'd0, 1'b1};
    vecs[5]  = '{8'h80, 1'b0, 17'd0, 12'h4B4, 17'd0, 8'd0, 1'b1};
    vecs[6]  = '{8'h12, 1'b0, 17'd0, 12'h4B4, 17'd0, 8'd0, 1'b1};
    vecs[7]  = '{8'h15, 1'b0, 17'd0, 12'h4B4, 17'd0, 8'd1, 1'b1};
    vecs[8]  = '{8'h40, 1'b1, 17'd0, 12'h540, 17'd1, 8'd1, 1'b1};
    vecs[9]  = '{8'h74, 1'b0, 17'd0, 12'h540, 17'd1, 8'd2, 1'b1};
    vecs[10] = '{8'h80, 1'b0, 17'd0, 12'h540, 17'd0, 8'd2, 1'b1};
    vecs[11] = '{8'h12, 1'b0, 17'd0, 12'h540, 17'd0, 8'd2, 1'b1};
    vecs[12] = '{8'h80, 1'b0, 17'd0, 12'h540, 17'd0, 8'd3, 1'b1};
    vecs[13] = '{8'h3F, 1'b0, 17'd0, 12'h540, 17'd0, 8'd3, 1'b1};
    vecs[14] = '{8'h7F, 1'b1, 17'd0, 12'hFFF, 17'd1, 8'd3, 1'b1};

    do_reset();
    chk_all_zero("reset");

    for (int i = 0; i < 15; i++) begin
      send(vecs[i].data);
      chk($sformatf("vec%0d wr_en", i),      32'(bus.wr_en),      32'(vecs[i].wr));
      chk($sformatf("vec%0d wr_addr", i),    32'(bus.wr_addr),    32'(vecs[i].addr));
      chk($sformatf("vec%0d wr_data", i),    32'(bus.wr_data),    32'(vecs[i].pix));
      chk($sformatf("vec%0d addr_count", i), 32'(bus.addr_count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d err_count", i),  32'(bus.err_count),  32'(vecs[i].err));
      chk($sformatf("vec%0d busy", i),       32'(bus.busy),       32'(vecs[i].busy));
      chk($sformatf("vec%0d frame_done", i), 32'(bus.frame_done), 32'd0);
    end

    // Timeout: error lands T clocks after the HI byte, then a stray LO adds another.
    do_reset();
    send(8'h80);
    send(8'h12);
    wr_seen = 1'b0;
    for (int i = 0; i < T - 1; i++) begin
      @(negedge clk);
      if (bus.wr_en) wr_seen = 1'b1;
    end
    chk("timeout not yet err", 32'(bus.err_count), 32'd0);
    @(negedge clk);
    chk("timeout err", 32'(bus.err_count), 32'd1);
    chk("timeout busy", 32'(bus.busy), 32'd1);
    repeat (9) begin
      @(negedge clk);
      if (bus.wr_en) wr_seen = 1'b1;
    end
    send(8'h74);
    if (bus.wr_en) wr_seen = 1'b1;
    chk("timeout then lo err", 32'(bus.err_count), 32'd2);
    chk("timeout no write", 32'(wr_seen), 32'd0);

    // Full 4x2 frame with frame_done on the last write.
    do_reset();
    send(8'h80);
    for (int p = 0; p < 8; p++) begin
      h6 = 6'(p * 5 + 1);
      l6 = 6'(p * 3 + 2);
      send({2'b00, h6});
      chk($sformatf("frame p%0d hi no wr", p), 32'(bus.wr_en), 32'd0);
      send({2'b01, l6});
      chk($sformatf("frame p%0d wr_en", p),      32'(bus.wr_en),      32'd1);
      chk($sformatf("frame p%0d wr_addr", p),    32'(bus.wr_addr),    32'(p));
      chk($sformatf("frame p%0d wr_data", p),    32'(bus.wr_data),    32'({h6, l6}));
      chk($sformatf("frame p%0d frame_done", p), 32'(bus.frame_done), (p == 7) ? 32'd1 : 32'd0);
      chk($sformatf("frame p%0d addr_count", p), 32'(bus.addr_count), (p == 7) ? 32'd0 : 32'(p + 1));
    end
    chk("frame end busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("frame_done one cycle", 32'(bus.frame_done), 32'd0);
    send(8'h12);
    send(8'h74);
    chk("post frame ignored wr", 32'(bus.wr_en), 32'd0);
    chk("post frame ignored err", 32'(bus.err_count), 32'd0);
    chk("post frame ignored busy", 32'(bus.busy), 32'd0);
    send(8'h80);
    chk("resync busy", 32'(bus.busy), 32'd1);
    send(8'h12);
    send(8'h74);
    chk("resync wr_en", 32'(bus.wr_en), 32'd1);
    chk("resync wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("resync wr_data", 32'(bus.wr_data), 32'h4B4);
    chk("resync addr_count", 32'(bus.addr_count), 32'd1);

    // Reset mid-pixel: outputs clear immediately and the half pixel is gone.
    send(8'h12);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all_zero("async reset");
    @(negedge clk);
    rst = 1'b1;
    send(8'h74);
    chk("after reset lo wr", 32'(bus.wr_en), 32'd0);
    chk("after reset lo err", 32'(bus.err_count), 32'd0);
    chk("after reset lo busy", 32'(bus.busy), 32'd0);
    send(8'h80);
    send(8'h74);
    chk("after reset sync lo wr", 32'(bus.wr_en), 32'd0);
    chk("after reset sync lo cnt", 32'(bus.addr_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
